mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory port: takes load/store requests from the execute stage and drives DataMem's memR/memW/address/Din while sampling Dout.
- DataMem is word-wide; this block supplies byte/halfword loads with sign/zero extension.
- Sub-word stores use read-modify-write.
- Misaligned and out-of-range accesses are flagged and never reach DataMem.

---
 rtl/mem_access_ctrl_pkg.sv | 35 +++
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_access_ctrl_lane_align.sv | 44 ++++
 rtl/mem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings, state type and legality rule for the data-memory access controller.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int DEFAULT_MEM_BYTES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        RMW_RD,
        RMW_WR,
        WR,
        RESP
    } state_t;

    // A request is illegal when its size code is unused, it is misaligned for its
    // size, or its containing word lies past the end of DataMem.
    function automatic logic req_illegal(input logic [1:0] size,
                                         input logic [31:0] addr,
                                         input int mem_bytes);
        logic bad_size;
        logic bad_align;
        logic bad_range;
        bad_size  = (size == 2'd3);
        bad_align = ((size == SZ_HALF) && addr[0]) ||
                    ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        bad_range = ({addr[31:2], 2'b00} > 32'(mem_bytes - 4));
        return bad_size || bad_align || bad_range;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and DataMem port of the memory access controller.
interface mem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        memR;
    logic        memW;
    logic [31:0] address;
    logic [31:0] Din;
    logic [31:0] Dout;

    // The master side is the execute stage together with DataMem.
    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, Dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, memR, memW, address, Din
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, Dout,
        output req_ready, resp_valid, resp_rdata, resp_err, memR, memW, address, Din
    );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Little-endian lane handling: sub-word load extraction/extension and
// read-modify-write merge of store data into a fetched word.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[{lo, 3'b000} +: 8];
        lane_half = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{sign & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{sign & lane_half[15]}}, lane_half};
            default: load_data = word;
        endcase
    end

    // Untouched lanes keep the fetched contents so a sub-word store never disturbs neighbours.
    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lo[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the data-memory port: sequences loads, word stores and
// read-modify-write sub-word stores onto a word-wide DataMem.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int RD_LAT    = 1
)
(
    input logic              clk,
    input logic              rst_n,
    mem_access_ctrl_if.slave bus
);

    state_t      state;
    state_t      next_state;

    logic [1:0]  cnt;
    logic [1:0]  lo;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] rdata_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;

    logic        err_now;
    logic        last_wait;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    assign err_now   = req_illegal(bus.req_size, bus.req_addr, MEM_BYTES);
    assign last_wait = (cnt == 2'(RD_LAT - 1));

    mem_lane_align u_align (
        .word      (bus.Dout),
        .lo        (lo),
        .size      (r_size),
        .sign      (r_sign),
        .wdata     (r_wdata),
        .load_data (load_val),
        .merged    (merge_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (err_now) begin
                        next_state = RESP;
                    end else if (!bus.req_we) begin
                        next_state = RD;
                    end else if (bus.req_size == SZ_WORD) begin
                        next_state = WR;
                    end else begin
                        next_state = RMW_RD;
                    end
                end
            end
            RD:      next_state = WAIT;
            RMW_RD:  next_state = WAIT;
            WAIT: begin
                if (last_wait) begin
                    next_state = r_we ? RMW_WR : RESP;
                end
            end
            RMW_WR:  next_state = RESP;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes come straight from the state so a reset drops them in the same instant.
    always_comb begin
        bus.req_ready  = (state == IDLE) && rst_n;
        bus.memR       = (state == RD) || (state == RMW_RD);
        bus.memW       = (state == WR) || (state == RMW_WR);
        bus.resp_valid = (state == RESP);
        bus.resp_err   = (state == RESP) && r_err;
        bus.resp_rdata = (state == RESP) ? rdata_q : 32'd0;
        bus.address    = addr_q;
        bus.Din        = din_q;
    end

    // Request capture at accept, read-latency counting and Dout capture in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 2'd0;
            lo      <= 2'd0;
            r_we    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_sign  <= 1'b0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            rdata_q <= 32'd0;
            addr_q  <= 32'd0;
            din_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lo      <= bus.req_addr[1:0];
                        r_we    <= bus.req_we;
                        r_size  <= bus.req_size;
                        r_sign  <= bus.req_sign;
                        r_wdata <= bus.req_wdata;
                        r_err   <= err_now;
                        rdata_q <= 32'd0;
                        cnt     <= 2'd0;
                        if (!err_now) begin
                            addr_q <= {bus.req_addr[31:2], 2'b00};
                            if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                                din_q <= bus.req_wdata;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (last_wait) begin
                        cnt <= 2'd0;
                        if (r_we) begin
                            din_q <= merge_val;
                        end else begin
                            rdata_q <= load_val;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: directed cases plus randomized traffic on RD_LAT = 1 and 3
// instances, compared against a byte-array reference model.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int          MEMB   = 1024;
    localparam logic [31:0] POISON = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        req_sign = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    int checks = 0;
    int failures = 0;
    int accepts = 0;
    int rcnt = 0, wcnt = 0, both = 0, misal = 0, resps = 0;
    logic [31:0] lastWA = 32'd0, lastWD = 32'd0;

    always #5 clk = ~clk;

    mem_access_ctrl_if b1();
    mem_access_ctrl_if b3();

    mem_access_ctrl #(.MEM_BYTES(MEMB), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    mem_access_ctrl #(.MEM_BYTES(MEMB), .RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    assign b1.req_valid = req_valid & ~sel;
    assign b1.req_we    = req_we;
    assign b1.req_size  = req_size;
    assign b1.req_sign  = req_sign;
    assign b1.req_addr  = req_addr;
    assign b1.req_wdata = req_wdata;
    assign b3.req_valid = req_valid & sel;
    assign b3.req_we    = req_we;
    assign b3.req_size  = req_size;
    assign b3.req_sign  = req_sign;
    assign b3.req_addr  = req_addr;
    assign b3.req_wdata = req_wdata;

    logic        o_ready, o_rv, o_err, o_memR, o_memW;
    logic [31:0] o_rdata, o_address, o_din;
    assign o_ready   = sel ? b3.req_ready  : b1.req_ready;
    assign o_rv      = sel ? b3.resp_valid : b1.resp_valid;
    assign o_err     = sel ? b3.resp_err   : b1.resp_err;
    assign o_rdata   = sel ? b3.resp_rdata : b1.resp_rdata;
    assign o_memR    = sel ? b3.memR       : b1.memR;
    assign o_memW    = sel ? b3.memW       : b1.memW;
    assign o_address = sel ? b3.address    : b1.address;
    assign o_din     = sel ? b3.Din        : b1.Din;

    // DataMem model driven by the DUT strobes; reference model is a separate array.
    logic [7:0]  phys [0:MEMB-1];
    logic [7:0]  refm [0:MEMB-1];
    logic [31:0] p1 = POISON;
    logic [31:0] p3 [0:2];

    assign b1.Dout = p1;
    assign b3.Dout = p3[2];

    function automatic logic [31:0] physWord(input logic [31:0] a);
        int i;
        if (a > 32'(MEMB - 4)) return POISON;
        i = int'(a);
        return {phys[i+3], phys[i+2], phys[i+1], phys[i]};
    endfunction

    task automatic physWrite(input logic [31:0] a, input logic [31:0] d);
        int i;
        if (a <= 32'(MEMB - 4)) begin
            i = int'(a);
            for (int k = 0; k < 4; k++) phys[i+k] = d[8*k +: 8];
        end
    endtask

    always @(posedge clk) begin
        if (b1.memW) physWrite(b1.address, b1.Din);
        if (b3.memW) physWrite(b3.address, b3.Din);
        p1    <= b1.memR ? physWord(b1.address) : POISON;
        p3[0] <= b3.memR ? physWord(b3.address) : POISON;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    always @(negedge clk) begin
        if (o_memR) rcnt++;
        if (o_memW) begin
            wcnt++;
            lastWA = o_address;
            lastWD = o_din;
        end
        if (o_memR && o_memW) both++;
        if ((o_memR || o_memW) && (o_address[1:0] != 2'b00)) misal++;
        if (o_rv) resps++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic setWord(input int a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            phys[a+k] = w[8*k +: 8];
            refm[a+k] = w[8*k +: 8];
        end
    endtask

    // Reference behaviour from the access rules: legality, byte-array read/write, latency.
    task automatic modelReq(input logic we, input logic [1:0] size, input logic sign,
                            input logic [31:0] addr, input logic [31:0] wdata, input int rdLat,
                            output logic [31:0] rd, output logic err, output int lat);
        int     n;
        longint base;
        n    = (size == 2'd3) ? 0 : (1 << size);
        base = (longint'(addr) / 4) * 4;
        err  = (n == 0) || (longint'(addr) % n != 0) || (base + 4 > MEMB);
        rd   = 32'd0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            for (int k = 0; k < n; k++) refm[int'(addr) + k] = wdata[8*k +: 8];
            lat = (n == 4) ? 2 : 3 + rdLat;
        end else begin
            for (int k = 0; k < n; k++) rd = rd | (32'(refm[int'(addr) + k]) << (8 * k));
            if (sign && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFFFFFF << (8 * n));
            lat = 2 + rdLat;
        end
    endtask

    // Caller is between edges with the DUT able to see the request before the next posedge.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sign,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rd, output logic err, output int lat,
                                 output int waited);
        req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        waited = 0;
        while (!o_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!o_ready) begin
            checkOutput("accept_timeout", {31'd0, o_ready}, 32'd1);
            req_valid = 1'b0;
            rd = 32'd0; err = 1'b0; lat = 0;
            return;
        end
        accepts++;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!o_rv && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd  = o_rdata;
        err = o_err;
    endtask

    task automatic doTxn(input string tag, input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output int waited);
        logic [31:0] erd;
        logic        eerr, err;
        int          elat, lat;
        modelReq(we, size, sign, addr, wdata, sel ? 3 : 1, erd, eerr, elat);
        applyStimulus(we, size, sign, addr, wdata, rd, err, lat, waited);
        checkOutput({tag, "_rdata"}, rd, erd);
        checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
        checkOutput({tag, "_lat"}, 32'(lat), 32'(elat));
    endtask

    task automatic randomPhase(input string name, input logic s, input int n);
        logic [1:0]  size;
        logic [31:0] addr, rd;
        int          r, w, acc0, resp0;
        @(negedge clk);
        sel = s;
        #1;
        acc0 = accepts; resp0 = resps; both = 0; misal = 0;
        for (int i = 0; i < n; i++) begin
            r    = int'($urandom % 16);
            size = (r == 0) ? 2'd3 : 2'(r % 3);
            addr = ($urandom % 2 == 1) ? 32'h40 + $urandom_range(0, 63) : $urandom_range(0, 1023);
            if ($urandom % 32 == 0) addr = $urandom;
            if ($urandom % 8 != 0 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
            doTxn($sformatf("%s_%0d", name, i), 1'($urandom % 2), size, 1'($urandom % 2),
                  addr, $urandom, rd, w);
        end
        @(negedge clk);
        #1;
        checkOutput({name, "_strobe_overlap"}, 32'(both), 32'd0);
        checkOutput({name, "_addr_align"}, 32'(misal), 32'd0);
        checkOutput({name, "_resp_count"}, 32'(resps - resp0), 32'(accepts - acc0));
    endtask

    initial begin
        logic [31:0] rd;
        int          w, r0, w0, resp0;

        for (int i = 0; i < MEMB; i++) begin
            phys[i] = 8'($urandom);
            refm[i] = phys[i];
        end
        p3[0] = POISON; p3[1] = POISON; p3[2] = POISON;

        #12;
        checkOutput("rst_ready", {31'd0, o_ready}, 32'd0);
        checkOutput("rst_strobes", {30'd0, o_memR, o_memW}, 32'd0);
        checkOutput("rst_resp", {30'd0, o_rv, o_err}, 32'd0);
        checkOutput("rst_rdata", o_rdata, 32'd0);
        checkOutput("rst_address", o_address, 32'd0);
        checkOutput("rst_din", o_din, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("post_rst_ready", {31'd0, o_ready}, 32'd1);

        w0 = wcnt; r0 = rcnt;
        doTxn("st_word", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, w);
        checkOutput("st_word_wpulses", 32'(wcnt - w0), 32'd1);
        checkOutput("st_word_waddr", lastWA, 32'h10);
        checkOutput("st_word_wdata", lastWD, 32'hDEADBEEF);
        doTxn("ld_word", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, rd, w);
        checkOutput("ld_word_value", rd, 32'hDEADBEEF);
        checkOutput("ld_word_rpulses", 32'(rcnt - r0), 32'd1);

        setWord(32'h20, 32'h11223344);
        w0 = wcnt; r0 = rcnt;
        doTxn("st_byte", 1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h000000AA, rd, w);
        checkOutput("st_byte_pulses", {16'(rcnt - r0), 16'(wcnt - w0)}, 32'h00010001);
        checkOutput("st_byte_din", lastWD, 32'h11AA3344);
        checkOutput("st_byte_mem", physWord(32'h20), 32'h11AA3344);

        setWord(32'h30, 32'h0000F080);
        doTxn("ld_b_sx", 1'b0, SZ_BYTE, 1'b1, 32'h30, 32'd0, rd, w);
        checkOutput("ld_b_sx_value", rd, 32'hFFFFFF80);
        doTxn("ld_h_zx", 1'b0, SZ_HALF, 1'b0, 32'h30, 32'd0, rd, w);
        checkOutput("ld_h_zx_value", rd, 32'h0000F080);
        doTxn("ld_h_hi", 1'b0, SZ_HALF, 1'b1, 32'h32, 32'd0, rd, w);
        checkOutput("ld_h_hi_value", rd, 32'h00000000);

        w0 = wcnt; r0 = rcnt;
        doTxn("err_wmis", 1'b0, SZ_WORD, 1'b0, 32'h13, 32'd0, rd, w);
        doTxn("err_hmis", 1'b1, SZ_HALF, 1'b0, 32'h21, 32'h1234, rd, w);
        doTxn("err_range", 1'b0, SZ_WORD, 1'b0, 32'h400, 32'd0, rd, w);
        doTxn("err_size3", 1'b0, 2'd3, 1'b0, 32'h40, 32'd0, rd, w);
        checkOutput("err_no_strobes", {16'(rcnt - r0), 16'(wcnt - w0)}, 32'd0);

        // Abandon a byte read-modify-write while it waits for Dout.
        setWord(32'h20, 32'h11223344);
        @(negedge clk);
        w0 = wcnt; resp0 = resps;
        req_we = 1'b1; req_size = SZ_BYTE; req_sign = 1'b0; req_addr = 32'h22; req_wdata = 32'hAA;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_strobes", {30'd0, o_memR, o_memW}, 32'd0);
        checkOutput("midrst_resp", {29'd0, o_rv, o_err, o_ready}, 32'd0);
        checkOutput("midrst_address", o_address, 32'd0);
        checkOutput("midrst_din", o_din, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_no_write", 32'(wcnt - w0), 32'd0);
        checkOutput("midrst_no_resp", 32'(resps - resp0), 32'd0);
        checkOutput("midrst_mem", physWord(32'h20), 32'h11223344);
        doTxn("post_midrst_ld", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0, rd, w);
        checkOutput("post_midrst_wait", 32'(w), 32'd0);
        checkOutput("post_midrst_value", rd, 32'h11223344);

        randomPhase("rnd_lat1", 1'b0, 60);
        randomPhase("rnd_lat3", 1'b1, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
